// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR filter: one signed multiplier, TAPS MAC cycles per sample,
// runtime-writable coefficients, optional output saturation.
module fir_filter_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        x_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     coef_err,
    output logic [OUT_W-1:0]         y_out,
    output logic                     out_valid
);
    localparam int AW    = $clog2(TAPS);
    localparam int P_W   = DATA_W + COEF_W;
    localparam int ACC_W = P_W + AW;
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [EXT_W-1:0] Y_MAX = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] Y_MIN = ~Y_MAX;
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, next_state;

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            idx;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [EXT_W-1:0]  ext;
    logic [OUT_W-1:0]         y_next;
    logic                     accept;
    logic                     coef_ok;
    logic                     coef_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MAC;
            MAC:     if (idx == LAST) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    // Widened compare so addresses past TAPS are caught when TAPS is not a power of two.
    assign coef_ok  = coef_we && in_ready && ({1'b0, coef_addr} < (AW + 1)'(TAPS));
    assign coef_bad = coef_we && !coef_ok;
    assign prod     = x[idx] * c[idx];

    always_comb begin
        shifted = acc >>> SHIFT;
        ext     = EXT_W'(shifted);
        y_next  = ext[OUT_W-1:0];
        if (SAT != 0) begin
            if (ext > Y_MAX)      y_next = Y_MAX[OUT_W-1:0];
            else if (ext < Y_MIN) y_next = Y_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            c[0]      <= COEF_W'(1);
            acc       <= '0;
            idx       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            coef_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            coef_err  <= coef_bad;
            if (coef_ok) c[coef_addr] <= coef_data;
            case (state)
                IDLE: if (accept) begin
                    x[0] <= x_in;
                    for (int unsigned k = 1; k < TAPS; k++) x[k] <= x[k-1];
                    acc <= '0;
                    idx <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                end
                OUT: begin
                    y_out     <= y_next;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter_mac.sv
// Scoreboard bench for fir_filter_mac: a TAPS=4 saturating instance and a
// TAPS=5 wrapping instance, directed vectors with hand-computed results.
module tb_fir_filter_mac;
    localparam int DW = 8;
    localparam int CW = 8;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic [DW-1:0] x_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          coef_we = 1'b0;
    logic [1:0]    coef_addr = '0;
    logic [CW-1:0] coef_data = '0;
    logic          coef_err;
    logic [15:0]   y_out;
    logic          out_valid;

    logic [DW-1:0] x5 = '0;
    logic          v5 = 1'b0;
    logic          r5;
    logic          we5 = 1'b0;
    logic [2:0]    a5 = '0;
    logic [CW-1:0] d5 = '0;
    logic          err5;
    logic [15:0]   y5;
    logic          ov5;

    fir_filter_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(4), .OUT_W(16), .SHIFT(0), .SAT(1)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .y_out(y_out), .out_valid(out_valid)
    );

    fir_filter_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(5), .OUT_W(16), .SHIFT(0), .SAT(0)) dut5 (
        .clk(clk), .rst(rst), .x_in(x5), .in_valid(v5), .in_ready(r5),
        .coef_we(we5), .coef_addr(a5), .coef_data(d5), .coef_err(err5),
        .y_out(y5), .out_valid(ov5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q0.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
                e0 = q0.pop_front();
                check("y_out", int'($signed(y_out)), e0.val);
                check("latency", cyc - e0.cyc, 5);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov5) begin
            if (q1.size() == 0) check("unexpected_out_valid5", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("y_out5", int'($signed(y5)), e1.val);
                check("latency5", cyc - e1.cyc, 6);
            end
        end
    end

    // Called at the negedge before the accepting edge; cyc+1 is the count seen one negedge after it.
    task automatic push(input int which, input int v);
        exp_t t;
        t.val = v;
        t.cyc = cyc + 1;
        if (which == 0) q0.push_back(t);
        else            q1.push_back(t);
    endtask

    task automatic send(input int which, input int v, input int exp);
        int n;
        n = 0;
        @(negedge clk);
        if (which == 0) begin x_in = DW'(v); in_valid = 1'b1; end
        else            begin x5 = DW'(v);   v5 = 1'b1; end
        while (((which == 0) ? !in_ready : !r5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if ((which == 0) ? in_ready : r5) push(which, exp);
        else check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        v5 = 1'b0;
    endtask

    task automatic wcoef(input int which, input int addr, input int data);
        int n;
        n = 0;
        @(negedge clk);
        while (((which == 0) ? !in_ready : !r5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (which == 0) begin coef_we = 1'b1; coef_addr = 2'(addr); coef_data = CW'(data); end
        else            begin we5 = 1'b1;     a5 = 3'(addr);        d5 = CW'(data); end
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        we5 = 1'b0;
        check("coef_write_ok", int'((which == 0) ? coef_err : err5), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q0.size() + q1.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy;
        int ov;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_coef_err", int'(coef_err), 0);
        check("rst_y_out", int'($signed(y_out)), 0);
        check("rst_y_out5", int'($signed(y5)), 0);
        @(negedge clk);
        rst = 1'b0;

        // Identity coefficients after reset
        send(0, 10, 10);
        send(0, 20, 20);
        send(0, 30, 30);
        drain();

        // Impulse response; a write during MAC must be rejected and leave c[2] intact
        do_reset();
        for (int k = 0; k < 4; k++) wcoef(0, k, k + 1);
        send(0, 1, 1);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'd2; coef_data = CW'(99);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("coef_err_mac", int'(coef_err), 1);
        @(posedge clk);
        #1;
        check("coef_err_pulse", int'(coef_err), 0);
        send(0, 0, 2);
        send(0, 0, 3);
        send(0, 0, 4);
        drain();

        // Moving sum
        do_reset();
        for (int k = 0; k < 4; k++) wcoef(0, k, 1);
        send(0, 10, 10);
        send(0, 20, 30);
        send(0, 30, 60);
        send(0, 40, 100);
        send(0, 50, 140);
        drain();

        // Overflow: saturate on TAPS=4, wrap on TAPS=5; out-of-range address on TAPS=5
        do_reset();
        @(negedge clk);
        we5 = 1'b1; a5 = 3'd5; d5 = CW'(9);
        @(posedge clk);
        #1;
        we5 = 1'b0;
        check("coef_err_range", int'(err5), 1);
        @(posedge clk);
        #1;
        check("coef_err_range_clear", int'(err5), 0);
        for (int k = 0; k < 4; k++) wcoef(0, k, 127);
        for (int k = 0; k < 5; k++) wcoef(1, k, 127);
        send(0, -128, -16256);
        send(0, -128, -32512);
        send(0, -128, -32768);
        send(1, -128, -16256);
        send(1, -128, -32512);
        send(1, -128, 16768);
        drain();

        // in_valid held high: one acceptance every six cycles
        do_reset();
        rdy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            x_in = DW'(5);
            in_valid = 1'b1;
            if (in_ready) begin
                push(0, 5);
                rdy++;
            end
        end
        in_valid = 1'b0;
        check("in_ready_duty", rdy, 2);
        drain();

        // Coefficient write coinciding with acceptance is used by that sample
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = CW'(3);
        x_in = DW'(4); in_valid = 1'b1;
        if (in_ready) push(0, 12);
        else check("coincident_ready", 0, 1);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        in_valid = 1'b0;
        check("coincident_coef_err", int'(coef_err), 0);
        drain();

        // Reset in mid-MAC aborts the sample and restores identity coefficients
        send(0, 3, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_y_out", int'($signed(y_out)), 0);
        check("abort_in_ready", int'(in_ready), 1);
        ov = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        check("abort_no_out_valid", ov, 0);
        send(0, 7, 7);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_filter_mac.md
FIR_FILTER_MAC -- requirements
Module: fir_filter_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width, signed two's complement.
REQ-002 SHALL have parameter COEF_W, default 8: coefficient width, signed two's complement.
REQ-003 SHALL have parameter TAPS, default 8, legal range 2..64: filter order + 1.
REQ-004 SHALL have parameter OUT_W, default 16: output width, signed.
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before output.
REQ-006 SHALL have parameter SAT, default 1: 1 = saturate on output overflow, 0 = truncate (wrap).
REQ-007 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port x_in, input, DATA_W: input sample.
REQ-010 SHALL have port in_valid, input, 1: x_in is valid.
REQ-011 SHALL have port in_ready, output, 1: block can accept a sample.
REQ-012 SHALL have port coef_we, input, 1: coefficient write strobe.
REQ-013 SHALL have port coef_addr, input, clog2(TAPS): coefficient index.
REQ-014 SHALL have port coef_data, input, COEF_W: coefficient value.
REQ-015 SHALL have port coef_err, output, 1: one-cycle pulse when a coefficient write is rejected.
REQ-016 SHALL have port y_out, output, OUT_W: filtered output, held between results.
REQ-017 SHALL have port out_valid, output, 1: one-cycle pulse when y_out updates.

Function
REQ-018 SHALL compute y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k] using one time-multiplexed signed multiplier.
REQ-019 SHALL use an accumulator of DATA_W+COEF_W+clog2(TAPS) bits so that no intermediate overflow occurs.
REQ-020 SHALL implement states IDLE, MAC and OUT, with in_ready = 1 only in IDLE.
REQ-021 SHALL, in IDLE on in_valid && in_ready: shift the delay line (x[0] <= x_in, x[k] <= x[k-1]), clear acc, set idx = 0, and go to MAC.
REQ-022 SHALL, in MAC each cycle: acc += x[idx]*c[idx] and idx++; after idx = TAPS-1 go to OUT.
REQ-023 SHALL, in OUT: register y_out = (acc >>> SHIFT) reduced to OUT_W (clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] if SAT=1, low OUT_W bits if SAT=0), pulse out_valid, and return to IDLE.
REQ-024 SHALL assert out_valid exactly TAPS+1 clock edges after the accepting edge; throughput is one sample per TAPS+2 cycles.
REQ-025 SHALL leave the delay line, acc and y_out unchanged while in_valid=0 in IDLE.
REQ-026 SHALL accept a coefficient write only in IDLE with coef_addr < TAPS, writing c[coef_addr] = coef_data on that edge.
REQ-027 SHALL, when a write coincides with a sample acceptance, perform both; that sample's MAC uses the new coefficient.
REQ-028 SHALL drop a write issued in MAC or OUT, or with coef_addr >= TAPS, leave the coefficients unchanged, and pulse coef_err for one cycle.

Reset
REQ-029 SHALL, on rst, immediately clear: state = IDLE, delay line = 0, acc = 0, idx = 0, y_out = 0, out_valid = 0, coef_err = 0.
REQ-030 SHALL, on rst, load coefficients to identity (c[0] = 1, all others 0), giving pass-through after reset.
REQ-031 SHALL abort any in-flight computation on rst mid-MAC/OUT, with no out_valid pulse for that sample.

Verification (TAPS=4, DATA_W=8, COEF_W=8, OUT_W=16, SHIFT=0, SAT=1)
REQ-032 SHALL cover: reset, then inputs 10, 20, 30 with default coefficients -> y_out = 10, 20, 30, each with out_valid 5 cycles after acceptance.
REQ-033 SHALL cover: load c = 1, 2, 3, 4, then impulse 1, 0, 0, 0 -> y_out = 1, 2, 3, 4.
REQ-034 SHALL cover: c = 1, 1, 1, 1, then inputs 10, 20, 30, 40, 50 -> y_out = 10, 30, 60, 100, 140.
REQ-035 SHALL cover: c = 127 x4, then inputs -128 x3 -> y_out = -16256, -32512, -32768 (saturated); with SAT=0 the third result is 16768.
REQ-036 SHALL cover: in_valid held high -> in_ready low for 5 of every 6 cycles; coef_we to addr 2 during MAC -> coef_err = 1 and c[2] unchanged; coef_addr = 5 in IDLE -> coef_err = 1.
REQ-037 SHALL cover: rst pulsed during MAC -> no out_valid, y_out = 0, coefficients back to identity, next input 7 -> y_out = 7.
